// File: rtl/ds_pkg.sv
// Shared constants and word type for every delta-sigma loop stage.
// All loop integrators and scalers import this package so widths stay consistent.
package ds_pkg;

  localparam int DS_W = 41;

  typedef logic signed [DS_W-1:0] ds_word_t;

  localparam ds_word_t DS_FS  = 41'sh020_0000_0000;
  localparam ds_word_t DS_MAX = {1'b0, {(DS_W-1){1'b1}}};
  localparam ds_word_t DS_MIN = {1'b1, {(DS_W-1){1'b0}}};

endpackage

// File: rtl/ds_integrator_stage_if.sv
// Sample-strobe interface between a loop stage and the integrator.
// The master side supplies samples and feedback; the slave side returns the state and flags.
interface ds_integrator_stage_if #(
  parameter int W = ds_pkg::DS_W
);

  logic                clr;
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                fb_bit;
  logic                out_valid;
  logic signed [W-1:0] out_state;
  logic                sat_active;
  logic                ovf_sticky;

  modport master (
    output clr, in_valid, in_data, fb_bit,
    input  out_valid, out_state, sat_active, ovf_sticky
  );

  modport slave (
    input  clr, in_valid, in_data, fb_bit,
    output out_valid, out_state, sat_active, ovf_sticky
  );

endinterface

// File: rtl/ds_sat_add.sv
// Combinational (W+1)-bit + W-bit adder that either clamps to the W-bit range or wraps.
// ovf reports any result outside the W-bit signed range, whichever mode is selected.
module ds_sat_add import ds_pkg::*; #(
  parameter int W      = DS_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [W:0]   a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] result,
  output logic                ovf
);

  localparam logic signed [W+1:0] MAX_X = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_X = {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] sum;
  logic                out_of_range;

  // Two guard bits make the sum exact, so range checks need no carry tricks.
  always_comb begin
    sum          = {{2{b[W-1]}}, b} + {a[W], a};
    out_of_range = (sum > MAX_X) || (sum < MIN_X);
    ovf          = out_of_range;
    result       = sum[W-1:0];
    if (SAT_EN && out_of_range) begin
      result = sum[W+1] ? MIN_X[W-1:0] : MAX_X[W-1:0];
    end
  end

endmodule

// File: rtl/ds_integrator_stage.sv
// Two-stage registered integrator: stage 1 forms in_data - feedback, stage 2 accumulates it
// with clamp or wrap, and tracks instantaneous and sticky overflow.
module ds_integrator_stage import ds_pkg::*; #(
  parameter int                  W      = DS_W,
  parameter logic signed [W-1:0] FS     = DS_FS,
  parameter bit                  SAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ds_integrator_stage_if.slave bus
);

  logic signed [W:0]   fb_val;
  logic signed [W:0]   d1_next;
  logic signed [W:0]   d1;
  logic                v1;
  logic signed [W-1:0] sum_res;
  logic                sum_ovf;

  // One extra bit keeps in_data +/- FS exact for any input.
  always_comb begin
    fb_val  = bus.fb_bit ? {FS[W-1], FS} : -{FS[W-1], FS};
    d1_next = {bus.in_data[W-1], bus.in_data} - fb_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else if (bus.clr) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        d1 <= d1_next;
      end
    end
  end

  ds_sat_add #(
    .W      (W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .a      (d1),
    .b      (bus.out_state),
    .result (sum_res),
    .ovf    (sum_ovf)
  );

  // State and flags move only when stage 1 hands over a sample; clr drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_state  <= '0;
      bus.out_valid  <= 1'b0;
      bus.sat_active <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else if (bus.clr) begin
      bus.out_state  <= '0;
      bus.out_valid  <= 1'b0;
      bus.sat_active <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.out_state  <= sum_res;
        bus.sat_active <= sum_ovf;
        bus.ovf_sticky <= bus.ovf_sticky | sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_ds_integrator_stage.sv
// Directed bench for ds_integrator_stage: one clamping instance and one wrapping instance
// driven from scenario tasks with hand-computed expected states.
module tb_ds_integrator_stage;
  import ds_pkg::*;

  localparam ds_word_t FS       = 41'sh020_0000_0000;
  localparam ds_word_t MAX_V    = 41'sh0FF_FFFF_FFFF;
  localparam ds_word_t MIN_V    = 41'sh100_0000_0000;
  localparam ds_word_t MAX_M_FS = 41'sh0DF_FFFF_FFFF;
  localparam ds_word_t WRAP_V   = 41'sh0E0_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ds_integrator_stage_if #(.W(DS_W)) sb ();
  ds_integrator_stage_if #(.W(DS_W)) wb ();

  ds_integrator_stage #(.W(DS_W), .FS(DS_FS), .SAT_EN(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  ds_integrator_stage #(.W(DS_W), .FS(DS_FS), .SAT_EN(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wb.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      sb.in_valid = i[0];
      sb.in_data  = 41'sd123;
      wb.in_valid = i[0];
      wb.in_data  = 41'sd123;
      tick();
      if ({sb.out_valid, sb.sat_active, sb.ovf_sticky, sb.out_state} !== '0) begin
        $display("FAIL reset_sat[%0d]: got v=%b s=%b o=%b st=%h, expected all 0", i,
                 sb.out_valid, sb.sat_active, sb.ovf_sticky, sb.out_state);
      end else passed++;
      total++;
      if ({wb.out_valid, wb.out_state} !== '0) begin
        $display("FAIL reset_wrap[%0d]: got v=%b st=%h, expected 0", i, wb.out_valid, wb.out_state);
      end else passed++;
      total++;
    end
    sb.in_valid = 1'b0;
    wb.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    if (sb.out_valid !== 1'b0 || sb.out_state !== '0) begin
      $display("FAIL reset_idle: got v=%b st=%h, expected v=0 st=0", sb.out_valid, sb.out_state);
    end else passed++;
    total++;
    sb.in_valid = 1'b1;
    sb.in_data  = 41'sd123;
    sb.fb_bit   = 1'b0;
    tick();
    sb.in_valid = 1'b0;
    if (sb.out_valid !== 1'b0) begin
      $display("FAIL reset_latency1: got out_valid=%b, expected 0", sb.out_valid);
    end else passed++;
    total++;
    tick();
    if (sb.out_valid !== 1'b1 || sb.out_state !== FS + 41'sd123) begin
      $display("FAIL reset_first: got v=%b st=%h, expected v=1 st=%h", sb.out_valid, sb.out_state,
               FS + 41'sd123);
    end else passed++;
    total++;
    tick();
    if (sb.out_valid !== 1'b0) begin
      $display("FAIL reset_pulse: got out_valid=%b, expected 0", sb.out_valid);
    end else passed++;
    total++;
  endtask

  task automatic test_step();
    ds_word_t exp_state [6];
    logic     exp_valid [6];
    exp_state = '{41'sd0, -FS, -(FS + FS), -(FS + FS + FS), -(FS + FS + FS), -(FS + FS + FS)};
    exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sb.clr = 1'b1;
    tick();
    sb.clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sb.in_valid = (i < 3);
      sb.in_data  = '0;
      sb.fb_bit   = 1'b1;
      tick();
      if (sb.out_valid !== exp_valid[i] || sb.out_state !== exp_state[i]) begin
        $display("FAIL step[%0d]: got v=%b st=%h, expected v=%b st=%h", i, sb.out_valid,
                 sb.out_state, exp_valid[i], exp_state[i]);
      end else passed++;
      total++;
    end
  endtask

  task automatic test_pos_sat();
    sb.clr = 1'b1;
    tick();
    sb.clr = 1'b0;
    sb.in_valid = 1'b1;
    sb.in_data  = MAX_V;
    sb.fb_bit   = 1'b0;
    tick();
    tick();
    tick();
    sb.in_valid = 1'b0;
    tick();
    tick();
    if (sb.out_state !== MAX_V || sb.sat_active !== 1'b1 || sb.ovf_sticky !== 1'b1) begin
      $display("FAIL pos_sat: got st=%h s=%b o=%b, expected st=%h s=1 o=1", sb.out_state,
               sb.sat_active, sb.ovf_sticky, MAX_V);
    end else passed++;
    total++;
    sb.in_valid = 1'b1;
    sb.in_data  = '0;
    sb.fb_bit   = 1'b1;
    tick();
    sb.in_valid = 1'b0;
    tick();
    if (sb.out_state !== MAX_M_FS || sb.sat_active !== 1'b0 || sb.ovf_sticky !== 1'b1) begin
      $display("FAIL pos_recover: got st=%h s=%b o=%b, expected st=%h s=0 o=1", sb.out_state,
               sb.sat_active, sb.ovf_sticky, MAX_M_FS);
    end else passed++;
    total++;
  endtask

  task automatic test_neg_wrap();
    wb.clr = 1'b1;
    tick();
    wb.clr = 1'b0;
    wb.in_valid = 1'b1;
    wb.in_data  = MIN_V + FS;
    wb.fb_bit   = 1'b1;
    tick();
    wb.in_valid = 1'b0;
    tick();
    if (wb.out_state !== MIN_V || wb.ovf_sticky !== 1'b0 || wb.sat_active !== 1'b0) begin
      $display("FAIL wrap_preload: got st=%h s=%b o=%b, expected st=%h s=0 o=0", wb.out_state,
               wb.sat_active, wb.ovf_sticky, MIN_V);
    end else passed++;
    total++;
    wb.in_valid = 1'b1;
    wb.in_data  = '0;
    wb.fb_bit   = 1'b1;
    tick();
    wb.in_valid = 1'b0;
    tick();
    if (wb.out_state !== WRAP_V || wb.sat_active !== 1'b1 || wb.ovf_sticky !== 1'b1) begin
      $display("FAIL wrap_neg: got st=%h s=%b o=%b, expected st=%h s=1 o=1", wb.out_state,
               wb.sat_active, wb.ovf_sticky, WRAP_V);
    end else passed++;
    total++;
  endtask

  task automatic test_clr_collision();
    sb.in_valid = 1'b1;
    sb.in_data  = 41'sd5;
    sb.fb_bit   = 1'b0;
    tick();
    sb.clr     = 1'b1;
    sb.in_data = 41'sd7;
    tick();
    sb.clr      = 1'b0;
    sb.in_valid = 1'b0;
    if ({sb.out_valid, sb.sat_active, sb.ovf_sticky, sb.out_state} !== '0) begin
      $display("FAIL clr_now: got v=%b s=%b o=%b st=%h, expected all 0", sb.out_valid,
               sb.sat_active, sb.ovf_sticky, sb.out_state);
    end else passed++;
    total++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (sb.out_valid !== 1'b0 || sb.out_state !== '0) begin
        $display("FAIL clr_drop[%0d]: got v=%b st=%h, expected v=0 st=0", i, sb.out_valid,
                 sb.out_state);
      end else passed++;
      total++;
    end
  endtask

  task automatic test_gapped();
    ds_word_t exp_state;
    logic     exp_valid;
    sb.clr = 1'b1;
    tick();
    sb.clr    = 1'b0;
    exp_state = '0;
    for (int c = 0; c < 12; c++) begin
      sb.in_valid = (c % 4 == 0);
      sb.in_data  = 41'sd1000;
      sb.fb_bit   = 1'b0;
      tick();
      exp_valid = (c % 4 == 1);
      if (exp_valid) exp_state = exp_state + FS + 41'sd1000;
      if (sb.out_valid !== exp_valid || sb.out_state !== exp_state) begin
        $display("FAIL gapped[%0d]: got v=%b st=%h, expected v=%b st=%h", c, sb.out_valid,
                 sb.out_state, exp_valid, exp_state);
      end else passed++;
      total++;
    end
    sb.in_valid = 1'b0;
  endtask

  initial begin
    sb.clr = 1'b0; sb.in_valid = 1'b0; sb.in_data = '0; sb.fb_bit = 1'b0;
    wb.clr = 1'b0; wb.in_valid = 1'b0; wb.in_data = '0; wb.fb_bit = 1'b0;
    test_reset();
    test_step();
    test_pos_sat();
    test_neg_wrap();
    test_clr_collision();
    test_gapped();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
